// File: rtl/btn_event_unit.sv
// btn_event_unit: synchronise, debounce and classify N_BTN buttons into per-channel pulses and one event stream
//
// Ports:
//   clk, rst            system clock; asynchronous active-high reset
//   btn_i               raw asynchronous button pins (BTN_ACTIVE_LOW selects pin polarity)
//   btn_level_o         debounced level per channel, 1 = pressed
//   press_o             one-cycle pulse per accepted press
//   release_o           one-cycle pulse per accepted release
//   long_o              one-cycle pulse when a hold reaches LONG_CYCLES
//   event_valid_o       merged event stream valid
//   event_id_o          channel index of the presented event
//   event_kind_o        00 press, 01 release, 10 long, 11 repeat
//   event_ready_i       consumer accepts the presented event
//   overflow_o          sticky flag: an event was dropped
//   clr_ovf_i           clears overflow_o (a same-cycle drop wins)
// Build option: define AUTOREPEAT_EN to emit kind-11 repeat events every REPEAT_CYCLES while in the long-press state.
module btn_event_unit #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [N_BTN-1:0] long_o,
  output logic             event_valid_o,
  output logic [2:0]       event_id_o,
  output logic [1:0]       event_kind_o,
  input  logic             event_ready_i,
  output logic             overflow_o,
  input  logic             clr_ovf_i
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int LW = $clog2(LONG_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [N_BTN-1:0] REL_PIN = {N_BTN{BTN_ACTIVE_LOW}};

  if (N_BTN < 1 || N_BTN > 8 || DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("btn_event_unit: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d, release_q, release_d, long_q, long_d;
  logic [N_BTN-1:0][DW-1:0] cnt_q, cnt_d;
  logic [N_BTN-1:0][LW-1:0] hold_q, hold_d;
  state_t state_q [N_BTN];
  state_t state_d [N_BTN];
  logic [N_BTN-1:0] pressed, tog, rep_evt, any_evt, sel_mask, dropped;
  logic valid_q, valid_d, ovf_q, ovf_d, loadable;
  logic [2:0] id_q, id_d, sel_id;
  logic [1:0] kind_q, kind_d, sel_kind;

`ifdef AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [N_BTN-1:0] rep_q, rep_d;
  logic [N_BTN-1:0][RW-1:0] rcnt_q, rcnt_d;
  always_comb begin
    rep_d = '0;
    rcnt_d = rcnt_q;
    for (int i = 0; i < N_BTN; i++) begin
      // in LONG a toggle is the release, which cancels any repeat due that cycle
      rep_d[i] = state_q[i] == LONG && !tog[i] && rcnt_q[i] == REP_LAST;
      rcnt_d[i] = state_q[i] == LONG && !tog[i] && !rep_d[i] ? rcnt_q[i] + 1'b1 : '0;
    end
  end
  assign rep_evt = rep_q;
`else
  assign rep_evt = '0;
`endif

  always_comb begin
    pressed = sync2_q ^ REL_PIN;
    tog = '0;
    cnt_d = cnt_q;
    level_d = level_q;
    press_d = '0;
    release_d = '0;
    long_d = '0;
    state_d = state_q;
    hold_d = hold_q;
    for (int i = 0; i < N_BTN; i++) begin
      // level flips once the mismatch has held for DEBOUNCE_CYCLES consecutive cycles
      tog[i] = pressed[i] != level_q[i] && cnt_q[i] == DB_LAST;
      cnt_d[i] = pressed[i] != level_q[i] && !tog[i] ? cnt_q[i] + 1'b1 : '0;
      level_d[i] = level_q[i] ^ tog[i];
      // level is 0 exactly in IDLE, so a toggle there is a rise and elsewhere a fall
      if (state_q[i] == IDLE) begin
        if (tog[i]) begin
          press_d[i] = 1'b1;
          state_d[i] = HELD;
          hold_d[i] = '0;
        end
      end else if (tog[i]) begin
        release_d[i] = 1'b1;
        state_d[i] = IDLE;
      end else if (state_q[i] == HELD) begin
        if (hold_q[i] == LONG_LAST) begin
          long_d[i] = 1'b1;
          state_d[i] = LONG;
        end else hold_d[i] = hold_q[i] + 1'b1;
      end
    end
    // a channel carries at most one pulse per cycle; the lowest channel index wins the stream
    any_evt = press_q | release_q | long_q | rep_evt;
    sel_mask = any_evt & (~any_evt + 1'b1);
    sel_id = '0;
    sel_kind = '0;
    for (int i = N_BTN - 1; i >= 0; i--)
      if (any_evt[i]) begin
        sel_id = 3'(i);
        sel_kind = release_q[i] ? 2'b01 : long_q[i] ? 2'b10 : rep_evt[i] ? 2'b11 : 2'b00;
      end
    loadable = !valid_q || event_ready_i;
    dropped = loadable ? any_evt & ~sel_mask : any_evt;
    valid_d = loadable ? |any_evt : valid_q;
    id_d = loadable && |any_evt ? sel_id : id_q;
    kind_d = loadable && |any_evt ? sel_kind : kind_q;
    ovf_d = |dropped || (ovf_q && !clr_ovf_i);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1_q <= REL_PIN;
      sync2_q <= REL_PIN;
      level_q <= '0;
      cnt_q <= '0;
      hold_q <= '0;
      press_q <= '0;
      release_q <= '0;
      long_q <= '0;
      for (int i = 0; i < N_BTN; i++) state_q[i] <= IDLE;
      valid_q <= 1'b0;
      id_q <= '0;
      kind_q <= '0;
      ovf_q <= 1'b0;
`ifdef AUTOREPEAT_EN
      rep_q <= '0;
      rcnt_q <= '0;
`endif
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      press_q <= press_d;
      release_q <= release_d;
      long_q <= long_d;
      state_q <= state_d;
      valid_q <= valid_d;
      id_q <= id_d;
      kind_q <= kind_d;
      ovf_q <= ovf_d;
`ifdef AUTOREPEAT_EN
      rep_q <= rep_d;
      rcnt_q <= rcnt_d;
`endif
    end

  assign btn_level_o = level_q;
  assign press_o = press_q;
  assign release_o = release_q;
  assign long_o = long_q;
  assign event_valid_o = valid_q;
  assign event_id_o = id_q;
  assign event_kind_o = kind_q;
  assign overflow_o = ovf_q;
endmodule
